// File: rtl/gamma_requant_dither.sv
// Requantizes one 12-bit gamma-corrected colour channel to 8 bits, using 1-D horizontal
// error diffusion with a seed that alternates per frame, or round-half-up. Syncs are delayed to match the data.
module gamma_requant_dither #(
  parameter bit DITHER_EN = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_vs,
  input  logic        I_hs,
  input  logic        I_de,
  input  logic [11:0] I_data,
  output logic        O_vs,
  output logic        O_hs,
  output logic        O_de,
  output logic [7:0]  O_data,
  output logic        O_frame_odd
);

  // Without dither the seed is the half-LSB offset, which turns truncation into round-half-up.
  localparam logic [3:0] SEED_EVEN = DITHER_EN ? 4'd12 : 4'd8;
  localparam logic [3:0] SEED_ODD  = DITHER_EN ? 4'd4  : 4'd8;
  localparam logic [3:0] ERR_FIXED = 4'd8;

  logic        r_vs_d;
  logic        r_hs_d;
  logic        r_de_d;
  logic        r_frame_odd;
  logic [3:0]  r_err;
  logic [8:0]  r_sum_hi;

  logic        w_vs_rise;
  logic        w_parity_next;
  logic [3:0]  w_seed;
  logic [3:0]  w_err_next;
  logic [12:0] w_sum;
  logic [7:0]  w_quant;

  assign w_vs_rise     = I_vs & ~r_vs_d;
  assign w_parity_next = r_frame_odd ^ w_vs_rise;
  assign w_seed        = w_parity_next ? SEED_ODD : SEED_EVEN;
  assign w_sum         = {1'b0, I_data} + {9'd0, r_err};

  // NOTE: assign a default before any branch so that no path leaves w_err_next unassigned, which would infer a latch.
  always_comb begin
    w_err_next = w_seed;
    if (I_de) begin
      w_err_next = DITHER_EN ? w_sum[3:0] : ERR_FIXED;
    end
  end

  // The fractional nibble already went into the error register, so only the integer part is kept.
  assign w_quant = r_sum_hi[8] ? 8'hFF : r_sum_hi[7:0];

  // NOTE: all state updates are non-blocking, so every register samples values from before the edge.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vs_d      <= 1'b0;
      r_hs_d      <= 1'b0;
      r_de_d      <= 1'b0;
      r_frame_odd <= 1'b0;
      r_err       <= SEED_EVEN;
      r_sum_hi    <= '0;
      O_vs        <= 1'b0;
      O_hs        <= 1'b0;
      O_de        <= 1'b0;
      O_data      <= '0;
    end else begin
      r_vs_d      <= I_vs;
      r_hs_d      <= I_hs;
      r_de_d      <= I_de;
      r_frame_odd <= w_parity_next;
      r_err       <= w_err_next;
      r_sum_hi    <= w_sum[12:4];
      O_vs        <= r_vs_d;
      O_hs        <= r_hs_d;
      O_de        <= r_de_d;
      O_data      <= r_de_d ? w_quant : 8'd0;
    end
  end

  assign O_frame_odd = r_frame_odd;

endmodule

// File: tb/tb_gamma_requant_dither.sv
// Self-checking bench: both DITHER_EN variants are checked every cycle against a line-level
// behavioural model, with literal sequences and per-line output-sum identities pinning the model.
module tb_gamma_requant_dither;

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       de;
    logic [7:0] data;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        vs    = 1'b0;
  logic        hs    = 1'b0;
  logic        de    = 1'b0;
  logic [11:0] data  = '0;

  logic       o_vs        [2];
  logic       o_hs        [2];
  logic       o_de        [2];
  logic [7:0] o_data      [2];
  logic       o_frame_odd [2];

  always #5 clk = ~clk;

  gamma_requant_dither #(.DITHER_EN(1'b0)) u_dut_plain (
    .I_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_hs(hs), .I_de(de), .I_data(data),
    .O_vs(o_vs[0]), .O_hs(o_hs[0]), .O_de(o_de[0]), .O_data(o_data[0]),
    .O_frame_odd(o_frame_odd[0])
  );

  gamma_requant_dither #(.DITHER_EN(1'b1)) u_dut_dith (
    .I_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_hs(hs), .I_de(de), .I_data(data),
    .O_vs(o_vs[1]), .O_hs(o_hs[1]), .O_de(o_de[1]), .O_data(o_data[1]),
    .O_frame_odd(o_frame_odd[1])
  );

  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;
  int   frames = 0;
  int   cap0[$];
  int   cap1[$];

  // Model state, index 0 = round-half-up instance, index 1 = dithering instance.
  exp_t m_s1      [2];
  exp_t m_out     [2];
  int   m_err     [2];
  bit   m_par     [2];
  bit   m_vs_prev [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int seed_of(input int k, input bit par);
    if (k == 0) return 8;
    return par ? 4 : 12;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k]      = '0;
      m_out[k]     = '0;
      m_par[k]     = 1'b0;
      m_err[k]     = seed_of(k, 1'b0);
      m_vs_prev[k] = 1'b0;
    end
  endtask

  // One pixel clock: quantize the pixel with the carried error, then advance the 2-deep delay line.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int s;
      int v;
      bit rise;
      rise     = vs && !m_vs_prev[k];
      m_out[k] = m_s1[k];
      v = 0;
      if (de) begin
        s        = int'(data) + m_err[k];
        v        = (s > 4095) ? 255 : s / 16;
        m_err[k] = (k == 1) ? s % 16 : 8;
      end
      m_par[k] = m_par[k] ^ rise;
      if (!de) m_err[k] = seed_of(k, m_par[k]);
      m_s1[k].vs   = vs;
      m_s1[k].hs   = hs;
      m_s1[k].de   = de;
      m_s1[k].data = 8'(v);
      m_vs_prev[k] = vs;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("o_vs[%0d]", k), o_vs[k], m_out[k].vs);
        check($sformatf("o_hs[%0d]", k), o_hs[k], m_out[k].hs);
        check($sformatf("o_de[%0d]", k), o_de[k], m_out[k].de);
        check($sformatf("o_data[%0d]", k), o_data[k], m_out[k].data);
        check($sformatf("o_frame_odd[%0d]", k), o_frame_odd[k], m_par[k]);
      end
    end
  end

  always @(negedge clk) begin
    if (o_de[0] === 1'b1) cap0.push_back(int'(o_data[0]));
    if (o_de[1] === 1'b1) cap1.push_back(int'(o_data[1]));
  end

  task automatic check_seq(input string name, input int got[$], input int want[$]);
    check({name, ".len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[i], want[i]);
  endtask

  task automatic cyc(input logic v, input logic h, input logic d, input logic [11:0] x);
    vs = v; hs = h; de = d; data = x;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, i == 0, 1'b0, 12'd0);
  endtask

  task automatic line_const(input int n, input logic [11:0] x);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, x);
  endtask

  task automatic clear_caps();
    cap0.delete();
    cap1.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int w[$];
    int gap, n, x, acc, sd, so;
    bit vsp, midvs, sumchk, mv;

    model_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    #1;
    check("rst.o_data", o_data[1], 0);
    check("rst.o_de", o_de[1], 0);
    check("rst.o_vs", o_vs[0], 0);
    check("rst.frame_odd", o_frame_odd[1], 0);
    cyc(1'b0, 1'b0, 1'b0, 12'd0);
    cyc(1'b0, 1'b0, 1'b0, 12'd0);
    rst_n = 1'b1;
    idle(3);

    // Rounding and saturation, with 2-cycle latency pinned.
    clear_caps();
    cyc(1'b0, 1'b0, 1'b1, 12'd2048);
    cyc(1'b0, 1'b0, 1'b1, 12'd4090);
    check("A.latency", o_data[0], 128);
    cyc(1'b0, 1'b0, 1'b1, 12'd7);
    idle(3);
    w = {128, 255, 0};
    check_seq("A.plain", cap0, w);
    check_seq("A.dith", cap1, w);

    // Even frame dither phase.
    clear_caps();
    line_const(8, 12'd24);
    idle(3);
    w = {2, 1, 2, 1, 2, 1, 2, 1};
    check_seq("B.dith", cap1, w);
    w = {2, 2, 2, 2, 2, 2, 2, 2};
    check_seq("B.plain", cap0, w);

    // Odd frame inverts the phase.
    cyc(1'b1, 1'b0, 1'b0, 12'd0);
    frames++;
    check("C.frame_odd", o_frame_odd[1], 1);
    idle(2);
    clear_caps();
    line_const(8, 12'd24);
    idle(3);
    w = {1, 2, 1, 2, 1, 2, 1, 2};
    check_seq("C.dith", cap1, w);

    // A 1-cycle DE gap reseeds: the 3-pixel line ends with error 12, which the gap must discard.
    clear_caps();
    line_const(3, 12'd24);
    cyc(1'b0, 1'b0, 1'b0, 12'd0);
    line_const(4, 12'd24);
    idle(3);
    w = {1, 2, 1, 1, 2, 1, 2};
    check_seq("D.dith", cap1, w);
    w = {2, 2, 2, 2, 2, 2, 2};
    check_seq("D.plain", cap0, w);

    // Asynchronous reset mid-line while outputs are non-zero and the frame is odd.
    line_const(4, 12'd2048);
    #2;
    rst_n = 1'b0;
    model_reset();
    frames = 0;
    #1;
    check("E.o_data", o_data[1], 0);
    check("E.o_de", o_de[1], 0);
    check("E.frame_odd", o_frame_odd[1], 0);
    check("E.o_data_plain", o_data[0], 0);
    cyc(1'b0, 1'b0, 1'b0, 12'd0);
    rst_n = 1'b1;
    idle(2);
    clear_caps();
    line_const(4, 12'd24);
    idle(3);
    w = {2, 1, 2, 1};
    check_seq("E.dith", cap1, w);

    // Single-pixel lines: (data+seed)>>4, then a saturated one.
    clear_caps();
    cyc(1'b0, 1'b0, 1'b1, 12'd100);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 12'd4095);
    idle(3);
    w = {7, 255};
    check_seq("F.dith", cap1, w);
    w = {6, 255};
    check_seq("F.plain", cap0, w);

    // Random lines; model checks every cycle, and sum lines check the error-diffusion identity.
    for (int l = 0; l < 30; l++) begin
      gap    = $urandom_range(1, 4);
      vsp    = ($urandom_range(0, 4) == 0);
      n      = $urandom_range(1, 32);
      midvs  = (l % 7 == 3);
      sumchk = !midvs && (l % 2 == 0);
      if (sumchk) idle(2);
      for (int g = 0; g < gap; g++) cyc(vsp && g == 0, g == 0, 1'b0, 12'd0);
      if (vsp) frames++;
      sd  = (frames % 2 == 1) ? 4 : 12;
      acc = 0;
      clear_caps();
      for (int p = 0; p < n; p++) begin
        if (sumchk) x = $urandom_range(0, 4080);
        else if (p % 5 == 0) x = $urandom_range(4000, 4095);
        else x = $urandom_range(0, 4095);
        acc += x;
        mv = midvs && (p == n / 2);
        cyc(mv, 1'b0, 1'b1, 12'(x));
        if (mv) frames++;
      end
      if (sumchk) begin
        idle(3);
        so = 0;
        foreach (cap1[i]) so += cap1[i];
        check($sformatf("sum.line%0d", l), so, (acc + sd) / 16);
      end
    end
    idle(4);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gamma_requant_dither.md
Name: gamma_requant_dither

Overview:
Downstream stage of the gamma LUTs. Consumes the 12-bit gamma-corrected pixel stream (one colour channel per instance) and requantizes it to 8 bits for the video output path. Uses 1-D horizontal error diffusion, with the seed alternating per frame to suppress banding, or plain round-half-up. Delays the video timing signals so they stay aligned with the data.

Parameters:
DITHER_EN, 1, 1 = error-diffusion dither; 0 = round-half-up only (no error carry)

Ports:
I_clk  input  1  pixel clock
I_rst_n  input  1  reset; one clock; reset is asynchronous and active-low
I_vs  input  1  vertical sync, active high
I_hs  input  1  horizontal sync, active high
I_de  input  1  data enable; I_data valid when high
I_data  input  12  gamma-corrected pixel, 0..4095
O_vs  output  1  I_vs delayed 2 cycles
O_hs  output  1  I_hs delayed 2 cycles
O_de  output  1  I_de delayed 2 cycles
O_data  output  8  requantized pixel, aligned with O_de
O_frame_odd  output  1  current frame parity used for seed selection

Behaviour:
- Reset: O_vs, O_hs, O_de = 0; O_data = 0; O_frame_odd = 0; internal err_q = seed for even frame; all pipeline registers = 0.
- Frame parity: vs_d registers I_vs. On the rising edge of I_vs (I_vs=1, vs_d=0), O_frame_odd toggles. After reset the first frame is even.
- Seed: DITHER_EN=1 → 4'd12 on even frames, 4'd4 on odd frames. DITHER_EN=0 → constant 4'd8.
- Stage 1 (registered, cycle +1):
  - sum (13 bits) = {1'b0, I_data} + err_q.
  - sum_q <= sum; de1 <= I_de.
  - vs/hs/de pass into a delay pipe at the same stage.
- Error register:
  - I_de=1 and DITHER_EN=1: err_q <= sum[3:0], so the error feeds the next pixel on the following cycle.
  - I_de=1 and DITHER_EN=0: err_q <= 4'd8.
  - I_de=0: err_q <= seed every cycle, so every line and every DE gap restarts from the seed. The seed uses the parity value being registered that cycle.
- Stage 2 (registered, cycle +2):
  - If de1=1: O_data <= (sum_q[12] ? 8'd255 : sum_q[11:4]). This saturates: any sum ≥ 4096 gives 255.
  - If de1=0: O_data <= 0.
- Latency: exactly 2 cycles from I_* to O_* for data and all syncs. Throughput is one pixel per clock with no backpressure.
- Arithmetic: unsigned only. The error is always in 0..15. No negative error and no carry into the adjacent line.
- Boundaries:
  - Back-to-back lines with a 1-cycle DE gap still reseed.
  - A 1-pixel line outputs (data+seed)>>4, saturated.
  - A vs edge occurring while DE=1 still toggles parity immediately.
  - A reset assertion mid-line clears outputs asynchronously. After release the first pixel uses the even seed.
  - I_data is assumed ≤ 4095, the full 12-bit range; saturation covers 4081..4095 plus error.

Test Plan:
- DITHER_EN=0, a DE line of I_data=2048, then 4090, then 7 → O_data=128, 255 (saturated), 0 (7+8=15>>4), each 2 cycles after the input. O_de/O_hs/O_vs are exactly 2-cycle delayed copies.
- DITHER_EN=1, even frame, constant I_data=24 for 8 pixels → O_data=2,1,2,1,2,1,2,1. Average 1.5 LSB.
- DITHER_EN=1, after one I_vs rising edge (O_frame_odd=1), same line → O_data=1,2,1,2,... The phase inverts versus the even frame.
- DITHER_EN=1, two lines of I_data=24 separated by a 1-cycle DE gap → the second line restarts at 2,1,... No error carried across the gap.
- Assert I_rst_n low mid-line with DE=1 → O_data=0, O_de=0 and O_frame_odd=0 immediately (asynchronous). After release, a line of 24 yields 2,1,2,1.
- Random 12-bit stream, DITHER_EN=1, compared against a reference model → bit-exact output. The sum of outputs over each line equals floor((Σinput+seed)/16), allowing for saturation.
